program_loader: RTL

Boot-time loader upstream of the rv32i_sc core: consumes a framed byte stream (future UART/JTAG bridge) and writes instruction and data words into the instruction BRAM and data BRAM write ports. It holds the core in stall (pc stall input) until a RUN command arrives, then hands control to the core. It replaces the bench-driven BRAM init loops in hardware.

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader_byte_packer.sv | 44 ++++
 rtl/program_loader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants, state encoding and helpers for the boot-time program loader.
package program_loader_pkg;

  localparam logic [7:0]  LDR_CMD_INSTR = 8'hA1;
  localparam logic [7:0]  LDR_CMD_DATA  = 8'hD1;
  localparam logic [7:0]  LDR_CMD_RUN   = 8'h5A;
  localparam int unsigned LDR_MAX_WORDS = 256;
  localparam int unsigned LDR_CNT_W     = 16;

  typedef enum logic [2:0] {
    LDR_CMD    = 3'd0,
    LDR_CNT_LO = 3'd1,
    LDR_CNT_HI = 3'd2,
    LDR_BYTE   = 3'd3,
    LDR_WRITE  = 3'd4,
    LDR_RUN    = 3'd5,
    LDR_ERROR  = 3'd6
  } ldr_state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic ldr_accepts(input ldr_state_e s);
    return (s == LDR_CMD) || (s == LDR_CNT_LO) || (s == LDR_CNT_HI) || (s == LDR_BYTE);
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Little-endian byte-to-word shifter: first byte lands in bits 7:0 of the word.
module program_loader_byte_packer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_nxt_c,
  output logic                  word_full_c
);

  localparam int unsigned N_BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W   = $clog2(N_BYTES);

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  always_comb begin
    word_nxt_c  = {byte_in, word_q[DATA_WIDTH-1:8]};
    word_full_c = shift_en && (idx_q == IDX_W'(N_BYTES - 1));
    word_d      = word_q;
    idx_d       = idx_q;
    if (clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_en) begin
      word_d = word_nxt_c;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader that fills instruction/data BRAMs and releases the core on RUN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WORDS  = LDR_MAX_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_err
);

  ldr_state_e             state_q, state_d;
  logic [7:0]             cnt_lo_q, cnt_lo_d;
  logic [LDR_CNT_W-1:0]   count_q, count_d;
  logic [LDR_CNT_W-1:0]   word_idx_q, word_idx_d;
  logic                   sec_data_q, sec_data_d;
  logic                   s_ready_q, s_ready_d;
  logic [ADDR_WIDTH-1:0]  i_w_addr_q, i_w_addr_d, d_w_addr_q, d_w_addr_d;
  logic [DATA_WIDTH-1:0]  i_w_dat_q, i_w_dat_d, d_w_dat_q, d_w_dat_d;
  logic                   i_w_enb_q, i_w_enb_d, d_w_enb_q, d_w_enb_d;
  logic                   cpu_stall_q, cpu_stall_d;
  logic                   load_done_q, load_done_d;
  logic                   load_err_q, load_err_d;

  logic                   xfer;
  logic                   pk_clear, pk_shift, pk_full;
  logic [DATA_WIDTH-1:0]  pk_word;
  logic [LDR_CNT_W-1:0]   count_c, idx_inc_c;
  logic [ADDR_WIDTH-1:0]  wr_addr_c;

  assign xfer = s_valid && s_ready_q;

  program_loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk         (clk),
    .rst_n       (rst),
    .clear       (pk_clear),
    .shift_en    (pk_shift),
    .byte_in     (s_dat),
    .word_nxt_c  (pk_word),
    .word_full_c (pk_full)
  );

  // Next-state and registered-output logic; outputs are decoded from state_d.
  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    sec_data_d = sec_data_q;
    i_w_addr_d = i_w_addr_q;
    i_w_dat_d  = i_w_dat_q;
    d_w_addr_d = d_w_addr_q;
    d_w_dat_d  = d_w_dat_q;
    i_w_enb_d  = 1'b0;
    d_w_enb_d  = 1'b0;
    pk_clear   = 1'b0;
    pk_shift   = 1'b0;
    count_c    = {s_dat, cnt_lo_q};
    idx_inc_c  = word_idx_q + LDR_CNT_W'(1);
    wr_addr_c  = ADDR_WIDTH'({word_idx_q, 2'b00});

    unique case (state_q)
      LDR_CMD: if (xfer) begin
        if (s_dat == LDR_CMD_INSTR) begin
          sec_data_d = 1'b0;
          state_d    = LDR_CNT_LO;
        end else if (s_dat == LDR_CMD_DATA) begin
          sec_data_d = 1'b1;
          state_d    = LDR_CNT_LO;
        end else if (s_dat == LDR_CMD_RUN) begin
          state_d = LDR_RUN;
        end else begin
          state_d = LDR_ERROR;
        end
      end
      LDR_CNT_LO: if (xfer) begin
        cnt_lo_d = s_dat;
        state_d  = LDR_CNT_HI;
      end
      LDR_CNT_HI: if (xfer) begin
        count_d    = count_c;
        word_idx_d = '0;
        pk_clear   = 1'b1;
        if (count_c == '0 || count_c > LDR_CNT_W'(MAX_WORDS)) state_d = LDR_ERROR;
        else                                                  state_d = LDR_BYTE;
      end
      LDR_BYTE: if (xfer) begin
        pk_shift = 1'b1;
        if (pk_full) begin
          state_d = LDR_WRITE;
          if (sec_data_q) begin
            d_w_enb_d  = 1'b1;
            d_w_addr_d = wr_addr_c;
            d_w_dat_d  = pk_word;
          end else begin
            i_w_enb_d  = 1'b1;
            i_w_addr_d = wr_addr_c;
            i_w_dat_d  = pk_word;
          end
        end
      end
      LDR_WRITE: begin
        word_idx_d = idx_inc_c;
        state_d    = (idx_inc_c == count_q) ? LDR_CMD : LDR_BYTE;
      end
      LDR_RUN:   state_d = LDR_RUN;
      LDR_ERROR: state_d = LDR_ERROR;
      default:   state_d = LDR_ERROR;
    endcase

    s_ready_d   = ldr_accepts(state_d);
    cpu_stall_d = (state_d != LDR_RUN);
    load_done_d = (state_d == LDR_RUN);
    load_err_d  = (state_d == LDR_ERROR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LDR_CMD;
      cnt_lo_q    <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      sec_data_q  <= 1'b0;
      s_ready_q   <= 1'b0;
      i_w_addr_q  <= '0;
      i_w_dat_q   <= '0;
      i_w_enb_q   <= 1'b0;
      d_w_addr_q  <= '0;
      d_w_dat_q   <= '0;
      d_w_enb_q   <= 1'b0;
      cpu_stall_q <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_lo_q    <= cnt_lo_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      sec_data_q  <= sec_data_d;
      s_ready_q   <= s_ready_d;
      i_w_addr_q  <= i_w_addr_d;
      i_w_dat_q   <= i_w_dat_d;
      i_w_enb_q   <= i_w_enb_d;
      d_w_addr_q  <= d_w_addr_d;
      d_w_dat_q   <= d_w_dat_d;
      d_w_enb_q   <= d_w_enb_d;
      cpu_stall_q <= cpu_stall_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign i_w_addr  = i_w_addr_q;
  assign i_w_dat   = i_w_dat_q;
  assign i_w_enb   = i_w_enb_q;
  assign d_w_addr  = d_w_addr_q;
  assign d_w_dat   = d_w_dat_q;
  assign d_w_enb   = d_w_enb_q;
  assign cpu_stall = cpu_stall_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule
